// File: rtl/wb_lcd_seq.sv
// Wishbone-fed HD44780 sequencer: power-up wait, fixed init list, then FIFO-queued
// commands driven with setup / E-pulse / hold / execution-time spacing.
module wb_lcd_seq #(
    parameter int clk_freq   = 100000000,
    parameter int fifo_depth = 4,
    parameter int t_setup    = 2,
    parameter int t_e_high   = 25,
    parameter int t_hold     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        E,
    output logic        RS,
    output logic        RW,
    output logic [7:0]  Data_out
);
    localparam int SHORT = clk_freq / 25000;
    localparam int LONG  = clk_freq / 610;
    localparam int PWR   = clk_freq / 50;
    localparam int AW    = $clog2(fifo_depth);
    localparam int LW    = AW + 1;

    typedef enum logic [2:0] {PWRUP, INIT, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;
    state_t state, state_nxt;

    logic [31:0]   cnt;
    logic [31:0]   dur;
    logic          last;
    logic          long_wait;
    logic [2:0]    init_idx;
    logic [8:0]    init_ent;
    logic          init_done;
    logic          ovf;
    logic [8:0]    fifo_mem [fifo_depth];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level;
    logic          full, empty, busy;
    logic          bus_req, push, ctrl_wr, flush, clr_ovf, accept, pop;
    logic          e_nxt, load_init, load_fifo;
    logic [31:0]   status;
    logic          unused_ok;

    assign RW        = 1'b0;
    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:3], wb_adr_i[1:0], wb_dat_i[31:9]};

    assign bus_req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign push    = bus_req & wb_we_i & ~wb_adr_i[2];
    assign ctrl_wr = bus_req & wb_we_i & wb_adr_i[2];
    assign flush   = ctrl_wr & wb_dat_i[1];
    assign clr_ovf = ctrl_wr & wb_dat_i[0];
    assign full    = (level == LW'(fifo_depth));
    assign empty   = (level == '0);
    assign pop     = load_fifo;
    // A pop on the same edge frees the slot a push into a full FIFO needs.
    assign accept  = push & (~full | pop);
    assign busy    = (state != IDLE) | ~empty;
    assign status  = {23'd0, 5'(level), ovf, init_done, full, busy};

    assign long_wait = ~RS & ((Data_out == 8'h01) | (Data_out == 8'h02));

    always_comb begin
        case (init_idx[1:0])
            2'd0:    init_ent = {1'b0, 8'h38};
            2'd1:    init_ent = {1'b0, 8'h0C};
            2'd2:    init_ent = {1'b0, 8'h01};
            default: init_ent = {1'b0, 8'h06};
        endcase
    end

    always_comb begin
        case (state)
            PWRUP:   dur = 32'(PWR);
            SETUP:   dur = 32'(t_setup);
            PULSE:   dur = 32'(t_e_high);
            HOLD:    dur = 32'(t_hold);
            WAIT:    dur = long_wait ? 32'(LONG) : 32'(SHORT);
            default: dur = 32'd1;
        endcase
    end
    assign last = (cnt == dur - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= PWRUP;
        else       state <= state_nxt;
    end

    // The end of WAIT makes the INIT/IDLE decision itself, so entries are
    // spaced by exactly setup + pulse + hold + wait.
    always_comb begin
        state_nxt = state;
        case (state)
            PWRUP: if (last) state_nxt = INIT;
            INIT:  state_nxt = SETUP;
            SETUP: if (last) state_nxt = PULSE;
            PULSE: if (last) state_nxt = HOLD;
            HOLD:  if (last) state_nxt = WAIT;
            WAIT:  if (last) state_nxt = ((init_idx < 3'd4) || !empty) ? SETUP : IDLE;
            IDLE:  if (!empty) state_nxt = SETUP;
            default: state_nxt = PWRUP;
        endcase
    end

    always_comb begin
        e_nxt     = (state_nxt == PULSE);
        load_init = (state_nxt == SETUP) && (state != SETUP) && (init_idx < 3'd4);
        load_fifo = (state_nxt == SETUP) && (state != SETUP) && (init_idx == 3'd4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            E         <= 1'b0;
            RS        <= 1'b0;
            Data_out  <= 8'h00;
            init_idx  <= '0;
            init_done <= 1'b0;
            ovf       <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
        end else begin
            cnt <= ((state_nxt != state) || (state == IDLE)) ? 32'd0 : cnt + 32'd1;
            E   <= e_nxt;
            if (load_init) begin
                {RS, Data_out} <= init_ent;
                init_idx       <= init_idx + 3'd1;
            end else if (load_fifo) begin
                {RS, Data_out} <= fifo_mem[rd_ptr];
            end
            if ((state == WAIT) && last && (init_idx == 3'd4))
                init_done <= 1'b1;

            wb_ack_o <= bus_req;
            wb_dat_o <= (bus_req && !wb_we_i && !wb_adr_i[2]) ? status : 32'd0;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (pop)    rd_ptr <= rd_ptr + AW'(1);
                if (accept) wr_ptr <= wr_ptr + AW'(1);
                level <= level + LW'(accept) - LW'(pop);
            end

            if (clr_ovf)                   ovf <= 1'b0;
            else if (push && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= wb_dat_i[8:0];
    end
endmodule

// File: tb/tb_wb_lcd_seq.sv
// Bench for wb_lcd_seq: expected LCD writes (RS, data, spacing from the previous E rise)
// are queued as stimulus is driven and checked by an E-edge monitor.
`timescale 1ns/1ps
module tb_wb_lcd_seq;
    localparam int CLK_FREQ = 1000000;
    localparam int SHORT    = CLK_FREQ / 25000;
    localparam int LONG     = CLK_FREQ / 610;
    localparam int PWR      = CLK_FREQ / 50;
    localparam int ENTRY    = 2 + 25 + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_adr = '0, wb_dat_w = '0, wb_dat_r;
    logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0, wb_ack;
    logic        E, RS, RW;
    logic [7:0]  Data_out;

    typedef struct { logic rs; logic [7:0] dat; int gap; } exp_t;
    exp_t exp_q[$];
    exp_t mon_x;

    int checks = 0, errors = 0;
    int cyc = 0, last_rise = 0;
    logic prev_e = 1'b0, unstable = 1'b0;
    int hi_len = 0;
    logic [8:0] lat = '0;

    wb_lcd_seq #(.clk_freq(CLK_FREQ)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r), .wb_sel_i(4'hF),
        .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_we_i(wb_we), .wb_ack_o(wb_ack),
        .E(E), .RS(RS), .RW(RW), .Data_out(Data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_e    = 1'b0;
            last_rise = 0;
        end else begin
            if (E && !prev_e) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_E at cycle %0d rs=%b dat=%h", cyc, RS, Data_out);
                end else begin
                    mon_x = exp_q.pop_front();
                    if ({RS, Data_out} !== {mon_x.rs, mon_x.dat}) begin
                        errors++;
                        $display("FAIL lcd_write got rs=%b dat=%h want rs=%b dat=%h",
                                 RS, Data_out, mon_x.rs, mon_x.dat);
                    end
                    if (mon_x.gap >= 0) begin
                        checks++;
                        if (cyc - last_rise != mon_x.gap) begin
                            errors++;
                            $display("FAIL e_spacing dat=%h got %0d want %0d",
                                     mon_x.dat, cyc - last_rise, mon_x.gap);
                        end
                    end
                end
                last_rise = cyc;
                hi_len    = 1;
                lat       = {RS, Data_out};
                unstable  = 1'b0;
            end else if (E) begin
                hi_len++;
                if ({RS, Data_out} !== lat) unstable = 1'b1;
            end else if (prev_e) begin
                checks++;
                if (hi_len != 25 || unstable || {RS, Data_out} !== lat) begin
                    errors++;
                    $display("FAIL e_pulse got len=%0d unstable=%b want len=25 stable", hi_len, unstable);
                end
            end
            prev_e = E;
        end
    end

    task automatic push_exp(input logic rs, input logic [7:0] dat, input int gap);
        exp_t x;
        x.rs = rs; x.dat = dat; x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        int n = 0;
        wb_adr = adr; wb_dat_w = dat; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        do begin @(negedge clk); n++; end while (!wb_ack && n < 8);
        checks++;
        if (wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack got %b want 1", wb_ack);
        end
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        int n = 0;
        wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        do begin @(negedge clk); n++; end while (!wb_ack && n < 8);
        dat = wb_dat_r;
        checks++;
        if (wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL rd_ack got %b want 1", wb_ack);
        end
        @(negedge clk);
        checks++;
        if (wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_one_clock got %b want 0", wb_ack);
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic push_init_list();
        push_exp(1'b0, 8'h38, PWR + 1 + 2);
        push_exp(1'b0, 8'h0C, ENTRY + SHORT);
        push_exp(1'b0, 8'h01, ENTRY + SHORT);
        push_exp(1'b0, 8'h06, ENTRY + LONG);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({E, RS, RW, Data_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_lcd got %b want 0", {E, RS, RW, Data_out});
        end
        checks++;
        if ({wb_ack, wb_dat_r} !== 33'd0) begin
            errors++;
            $display("FAIL reset_wb got %h want 0", {wb_ack, wb_dat_r});
        end
    endtask

    task automatic test_init_and_overflow();
        logic [31:0] st;
        push_init_list();
        reset = 1'b0;
        wb_write(32'h0, 32'h141); push_exp(1'b1, 8'h41, ENTRY + SHORT);
        wb_write(32'h0, 32'h142); push_exp(1'b1, 8'h42, ENTRY + SHORT);
        wb_write(32'h0, 32'h080); push_exp(1'b0, 8'h80, ENTRY + SHORT);
        wb_write(32'h0, 32'h143); push_exp(1'b1, 8'h43, ENTRY + SHORT);
        wb_write(32'h0, 32'h144);
        wb_read(32'h0, st);  check_status("status_full_ovf", st, 32'h4B);
        wb_write(32'h4, 32'h1);
        wb_read(32'h0, st);  check_status("status_ovf_clr", st, 32'h43);
        wb_read(32'h4, st);  check_status("ctrl_read", st, 32'h0);
        wait_drain(30000);
        wait_until(last_rise + 80);
        wb_read(32'h0, st);  check_status("status_init_done", st, 32'h04);
    endtask

    task automatic test_data_write();
        logic [31:0] st;
        int rise;
        wb_write(32'h0, 32'h141); push_exp(1'b1, 8'h41, -1);
        wb_read(32'h0, st);  check_status("busy_after_write", st & 32'h1, 32'h1);
        wait_drain(200);
        rise = last_rise;
        wait_until(rise + 63);
        wb_read(32'h0, st);  check_status("busy_before_end", st, 32'h05);
        wait_until(rise + 67);
        wb_read(32'h0, st);  check_status("idle_after_69", st, 32'h04);
    endtask

    task automatic test_clear_cmd();
        wb_write(32'h0, 32'h001); push_exp(1'b0, 8'h01, -1);
        wb_write(32'h0, 32'h002); push_exp(1'b0, 8'h02, ENTRY + LONG);
        wb_write(32'h0, 32'h003); push_exp(1'b0, 8'h03, ENTRY + LONG);
        wb_write(32'h0, 32'h141); push_exp(1'b1, 8'h41, ENTRY + SHORT);
        wait_drain(5000);
    endtask

    task automatic test_push_pop_full();
        logic [31:0] st;
        int n = 0;
        wait_until(last_rise + 80);
        wb_write(32'h0, 32'h001); push_exp(1'b0, 8'h01, -1);
        for (int i = 0; i < 4; i++) begin
            wb_write(32'h0, 32'h150 + 32'(i));
            push_exp(1'b1, 8'h50 + 8'(i), (i == 0) ? ENTRY + LONG : ENTRY + SHORT);
        end
        wb_read(32'h0, st);  check_status("status_full", st, 32'h47);
        while (exp_q.size() > 4 && n < 100) begin @(negedge clk); n++; end
        wait_until(last_rise + LONG + 26);
        wb_write(32'h0, 32'h154); push_exp(1'b1, 8'h54, ENTRY + SHORT);
        wb_read(32'h0, st);  check_status("status_push_pop", st, 32'h47);
        wait_drain(3000);
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] st;
        int n = 0;
        wait_until(last_rise + 80);
        wb_write(32'h0, 32'h141); push_exp(1'b1, 8'h41, -1);
        wb_write(32'h0, 32'h142);
        wb_write(32'h0, 32'h143);
        while (!E && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (E !== 1'b1) begin
            errors++;
            $display("FAIL e_wait got %b want 1", E);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({E, RS, Data_out} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_pulse got %b want 0", {E, RS, Data_out});
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_init_list();
        reset = 1'b0;
        wb_read(32'h0, st);  check_status("status_after_reset", st, 32'h01);
        wait_drain(25000);
        wait_until(last_rise + 100);
        wb_read(32'h0, st);  check_status("status_reinit", st, 32'h04);
    endtask

    initial begin
        test_reset();
        test_init_and_overflow();
        test_data_write();
        test_clear_cmd();
        test_push_pop_full();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
